// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA engine: FSM states, widths, write-enable codes.
package dma_pkg;
  localparam int ADDR_W = 15;
  localparam int CNT_W  = 16;

  localparam logic [1:0] WE_WRITE = 2'b11;
  localparam logic [1:0] WE_READ  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DEV,
    MEM,
    ACK,
    DONE,
    ERR,
    RELEASE
  } state_t;
endpackage

// File: rtl/dma_if.sv
// Memory-side bus of the DMA engine. master = engine, slave = memory.
interface dma_if;
  import dma_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [1:0]        mem_we;
  logic [15:0]       mem_dout;
  logic [15:0]       mem_din;
  logic              mem_ready;
  logic              mem_resp;

  modport master (
    output mem_addr, mem_en, mem_we, mem_dout,
    input  mem_din, mem_ready, mem_resp
  );

  modport slave (
    input  mem_addr, mem_en, mem_we, mem_dout,
    output mem_din, mem_ready, mem_resp
  );
endinterface

// File: rtl/dma_mem_port.sv
// Memory access port: launches one access per 'issue', holds en/addr/we until
// the memory answers or the wait budget runs out, and decodes the outcome.
module dma_mem_port
  import dma_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              acc_done,
  output logic              acc_err,
  dma_if.master             mem
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic              en;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       tcnt;
  logic              timeout;

  // Last allowed waiting cycle without ready ends the access as an error.
  assign timeout  = en && !mem.mem_ready && (tcnt == TO_LAST);
  assign acc_done = en && mem.mem_ready && !mem.mem_resp;
  assign acc_err  = en && ((mem.mem_ready && mem.mem_resp) || timeout);

  // Access hold registers and wait counter; async reset drops mem_en at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en     <= 1'b0;
      we     <= WE_READ;
      addr_q <= '0;
      tcnt   <= '0;
    end else if (issue) begin
      en     <= 1'b1;
      we     <= write ? WE_WRITE : WE_READ;
      addr_q <= addr;
      tcnt   <= '0;
    end else if (en && (mem.mem_ready || timeout)) begin
      en     <= 1'b0;
      we     <= WE_READ;
      tcnt   <= '0;
    end else if (en) begin
      tcnt   <= tcnt + 16'd1;
    end
  end

  assign mem.mem_en   = en;
  assign mem.mem_we   = we;
  assign mem.mem_addr = addr_q;
  assign mem.mem_dout = wdata;
endmodule

// File: rtl/dma_engine.sv
// Single-channel word DMA between a request/ack device and a ready/resp memory.
// Optional macro DMA_BOUNDS_CHECK_EN: stepping past word address 0x7FFF with
// words still left is an error instead of a silent wrap to 0.
module dma_engine
  import dma_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_rqst,
  input  logic        dma_rd_wr,
  input  logic [15:0] dma_start_address,
  input  logic [15:0] dma_num_words,
  input  logic        dev_ack,
  input  logic [15:0] dev_out,
  output logic [15:0] dev_in,
  output logic        dma_ack,
  output logic        dma_end_flag,
  output logic        dma_error_flag,
  output logic        busy,
  dma_if.master       mem
);
  state_t            state, next;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic              rd;
  logic              abort_q;
  logic [15:0]       wdata;
  logic              issue;
  logic              acc_done, acc_err;
  logic              wrap_err;
  logic              addr_lsb_unused;

  // Byte address bit 0 has no meaning for word transfers.
  assign addr_lsb_unused = dma_start_address[0];

`ifdef DMA_BOUNDS_CHECK_EN
  assign wrap_err = (addr == '1);
`else
  assign wrap_err = 1'b0;
`endif

  dma_mem_port #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_port (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .write    (!rd),
    .addr     (addr),
    .wdata    (wdata),
    .acc_done (acc_done),
    .acc_err  (acc_err),
    .mem      (mem)
  );

  // Next-state and access launch; dev_ack is only looked at in WAIT_DEV.
  always_comb begin
    next  = state;
    issue = 1'b0;
    case (state)
      IDLE:     if (dma_rqst) next = (dma_num_words == '0) ? DONE : WAIT_DEV;
      WAIT_DEV: if (!dma_rqst) next = IDLE;
                else if (dev_ack) begin
                  next  = MEM;
                  issue = 1'b1;
                end
      MEM:      if (acc_done || acc_err)
                  next = (abort_q || !dma_rqst) ? IDLE : (acc_err ? ERR : ACK);
      ACK:      if (cnt == CNT_W'(1)) next = DONE;
                else if (wrap_err)    next = ERR;
                else                  next = WAIT_DEV;
      DONE:     next = RELEASE;
      ERR:      next = RELEASE;
      RELEASE:  if (!dma_rqst) next = IDLE;
      default:  next = IDLE;
    endcase
  end

  // State, transfer bookkeeping and data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      cnt     <= '0;
      rd      <= 1'b0;
      abort_q <= 1'b0;
      wdata   <= '0;
      dev_in  <= '0;
    end else begin
      state   <= next;
      // A dropped request during an access is remembered until it completes.
      abort_q <= (state == MEM && next == MEM) ? (abort_q | !dma_rqst) : 1'b0;
      case (state)
        IDLE: if (dma_rqst) begin
          addr <= dma_start_address[15:1];
          cnt  <= dma_num_words;
          rd   <= dma_rd_wr;
        end
        WAIT_DEV: if (issue && !rd) wdata <= dev_out;
        MEM:      if (acc_done && rd) dev_in <= mem.mem_din;
        ACK: begin
          addr <= addr + 1'b1;
          cnt  <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dma_ack        = (state == ACK);
  assign dma_end_flag   = (state == DONE);
  assign dma_error_flag = (state == ERR);
  assign busy           = (state != IDLE);
endmodule

// File: doc/dma_engine.md
DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, max cycles a memory access may wait for mem_ready (range 1..65535).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- dma_rqst  in  1  device transfer request (level)
- dma_rd_wr  in  1  1 = memory->device (read), 0 = device->memory (write)
- dma_start_address  in  16  byte address of first word; bit 0 ignored
- dma_num_words  in  16  word count
- dev_ack  in  1  device ready for next word
- dev_out  in  16  device write data
- dev_in  out  16  read data to device
- dma_ack  out  1  one-cycle word-complete strobe
- dma_end_flag  out  1  one-cycle transfer-complete strobe
- dma_error_flag  out  1  one-cycle error strobe
- mem_addr  out  15  memory word address
- mem_en  out  1  memory access request
- mem_we  out  2  byte write enables
- mem_dout  out  16  memory write data
- mem_din  in  16  memory read data
- mem_ready  in  1  access complete this cycle
- mem_resp  in  1  access error, valid with mem_ready
- busy  out  1  high in any state except IDLE

Function
REQ-003 SHALL implement FSM states IDLE, WAIT_DEV, MEM, ACK, DONE, ERR, RELEASE.
REQ-004 IDLE: on dma_rqst=1, SHALL latch address[15:1], count, direction; count=0 -> DONE, else -> WAIT_DEV.
REQ-005 WAIT_DEV: SHALL wait for dev_ack=1; write direction SHALL capture dev_out into mem_dout in that same cycle (dev_ack may be a one-cycle pulse); then -> MEM.
REQ-006 MEM: mem_en=1, mem_addr=current address, mem_we=2'b11 for write, 2'b00 for read; all held stable until mem_ready=1.
REQ-007 MEM on mem_ready=1: mem_resp=1 -> ERR; else read direction SHALL register mem_din into dev_in, then -> ACK.
REQ-008 ACK: dma_ack=1 for exactly one cycle; address increments by 1 word and count decrements; count reaching 0 -> DONE, else -> WAIT_DEV.
REQ-009 dev_ack SHALL not be sampled in the cycle of dma_ack; the earliest sample is in the following WAIT_DEV cycle.
REQ-010 dev_in SHALL hold its value until the next read completes; it is valid in the ACK cycle.
REQ-011 DONE: dma_end_flag=1 for one cycle -> RELEASE. ERR: dma_error_flag=1 for one cycle -> RELEASE.
REQ-012 RELEASE: SHALL wait for dma_rqst=0 before returning to IDLE; no re-arm while the request stays high.
REQ-013 dma_rqst=0 in WAIT_DEV SHALL abort to IDLE with no flags; in MEM, the access SHALL complete, then go to IDLE with no dma_ack.
REQ-014 Timeout counter SHALL count MEM cycles with mem_ready=0; reaching TIMEOUT_CYC -> ERR with mem_en dropped.
REQ-015 Address arithmetic SHALL be 15-bit modulo; count=0xFFFF SHALL transfer 65535 words.
REQ-016 Latency: mem_ready in cycle N gives dma_ack in cycle N+1 and dma_end_flag in N+2 for the last word.

Reset
REQ-017 Reset SHALL force IDLE; dev_in, mem_dout=0; dma_ack, dma_end_flag, dma_error_flag, mem_en, mem_we, busy=0; mem_addr, counters=0.
REQ-018 Reset mid-transfer SHALL drop mem_en immediately, with no pending strobe emitted after release.

Configuration
REQ-019 Macro DMA_BOUNDS_CHECK_EN defined: the ACK increment from address 0x7FFF with count remaining >0 SHALL go to ERR instead of wrapping. Undefined: address wraps silently to 0.

Structure
REQ-020 Package dma_pkg SHALL hold the FSM state typedef, the width constants (ADDR_W=15, CNT_W=16), and the mem_we encodings.
REQ-021 Sub-module dma_mem_port SHALL own the mem_en/addr/we hold, the timeout counter, and the ready/resp decode; the FSM stays in dma_engine.

Verification
REQ-022 Read: start=0x0200, n=3, dev_ack=1, mem_ready after 1 cycle -> addrs 0x100,0x101,0x102; 3 dma_ack pulses with dev_in=mem data; one dma_end_flag.
REQ-023 Write non-atomic: n=2, dev_ack pulsed with dev_out=0xA5A5 then 0x5A5A -> mem_we=11 writes in order; no access before each pulse.
REQ-024 n=0 -> dma_end_flag within 2 cycles, mem_en never asserted.
REQ-025 mem_ready held 0 with TIMEOUT_CYC=4 -> dma_error_flag after 4 MEM cycles; no dma_ack.
REQ-026 mem_resp=1 on word 2 of 4 -> one dma_ack then dma_error_flag; engine stays in RELEASE until dma_rqst=0.
REQ-027 With DMA_BOUNDS_CHECK_EN: start=0xFFFE, n=2 -> error after first word; without it -> second access at mem_addr 0x0000.
